// File: rtl/arm_poll_scheduler_if.sv
// Sequencer-facing bundle for arm_poll_scheduler: trigger pulses and committed frames out,
// completion flag, angle result and NAK status back from the I2C sequencer.
interface arm_poll_scheduler_if;
  logic        elbow_read_joint_angle;
  logic        write_hand;
  logic [87:0] arm_board_commandFrame_0;
  logic [87:0] arm_board_commandFrame_1;
  logic [87:0] arm_board_commandFrame_2;
  logic [87:0] arm_board_commandFrame_3;
  logic        done;
  logic [11:0] angle;
  logic        ack_error;

  modport master (
    output elbow_read_joint_angle, write_hand,
    output arm_board_commandFrame_0, arm_board_commandFrame_1,
    output arm_board_commandFrame_2, arm_board_commandFrame_3,
    input  done, angle, ack_error
  );

  modport slave (
    input  elbow_read_joint_angle, write_hand,
    input  arm_board_commandFrame_0, arm_board_commandFrame_1,
    input  arm_board_commandFrame_2, arm_board_commandFrame_3,
    output done, angle, ack_error
  );
endinterface

// File: rtl/arm_poll_scheduler.sv
// Periodic elbow-angle poll and hand-frame commit scheduler for the arm I2C sequencer.
// Build macro ANGLE_FILTER_EN: joint_angle becomes a 1/4-gain IIR of good samples instead of the raw angle.
module arm_poll_scheduler #(
  parameter int TICK_CYCLES = 500000,
  parameter int WDOG_CYCLES = 65535
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 wr_en,
  input  logic [3:0]           wr_addr,
  input  logic [31:0]          wr_data,
  arm_poll_scheduler_if.master seq,
  output logic [11:0]          joint_angle,
  output logic                 angle_valid,
  output logic [3:0]           frame_pending,
  output logic [7:0]           error_count,
  output logic [7:0]           timeout_count,
  output logic [7:0]           overrun_count,
  output logic                 busy
);
  localparam int TK_W = $clog2(TICK_CYCLES);
  localparam int WD_W = $clog2(WDOG_CYCLES + 1);
  localparam logic [TK_W-1:0] TICK_LAST = TK_W'(TICK_CYCLES - 1);
  localparam logic [WD_W-1:0] WDOG_LAST = WD_W'(WDOG_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE, ISSUE_READ, WAIT_READ_ACC, WAIT_READ, ISSUE_WRITE, WAIT_WRITE_ACC, WAIT_WRITE
  } state_t;

  state_t          state, state_nxt;
  logic [TK_W-1:0] tick_cnt;
  logic            tick;
  logic [WD_W-1:0] wdog_cnt;
  logic            in_wait, wdog_last, wdog_hit, rd_done, wr_done;
  logic [87:0]     stage [4];
  logic [87:0]     frame [4];
`ifdef ANGLE_FILTER_EN
  logic            first_good;
`endif

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  function automatic logic [11:0] filt_step(input logic [11:0] cur, input logic [11:0] smp);
    logic signed [12:0] diff;
    diff = $signed({1'b0, smp}) - $signed({1'b0, cur});
    return cur + 12'(diff >>> 2);
  endfunction

  assign tick      = (tick_cnt == TICK_LAST);
  assign in_wait   = state inside {WAIT_READ_ACC, WAIT_READ, WAIT_WRITE_ACC, WAIT_WRITE};
  assign wdog_last = (wdog_cnt == WDOG_LAST);
  assign busy      = (state != IDLE);

  assign seq.elbow_read_joint_angle   = (state == ISSUE_READ);
  assign seq.write_hand               = (state == ISSUE_WRITE);
  assign seq.arm_board_commandFrame_0 = frame[0];
  assign seq.arm_board_commandFrame_1 = frame[1];
  assign seq.arm_board_commandFrame_2 = frame[2];
  assign seq.arm_board_commandFrame_3 = frame[3];

  // Free-running poll period, independent of the transaction FSM.
  always_ff @(posedge clock) begin
    if (reset || tick) tick_cnt <= '0;
    else               tick_cnt <= tick_cnt + 1'b1;
  end

  // Completion needs done low (ACC state) then high; done already high on entry is ignored.
  always_comb begin
    state_nxt = state;
    wdog_hit  = 1'b0;
    rd_done   = 1'b0;
    wr_done   = 1'b0;
    case (state)
      IDLE:        if (tick) state_nxt = ISSUE_READ;
      ISSUE_READ:  state_nxt = WAIT_READ_ACC;
      WAIT_READ_ACC: begin
        if (!seq.done)     state_nxt = WAIT_READ;
        else if (wdog_last) begin wdog_hit = 1'b1; state_nxt = IDLE; end
      end
      WAIT_READ: begin
        if (seq.done) begin
          rd_done   = 1'b1;
          state_nxt = (frame_pending != 4'b0) ? ISSUE_WRITE : IDLE;
        end else if (wdog_last) begin
          wdog_hit = 1'b1; state_nxt = IDLE;
        end
      end
      ISSUE_WRITE: state_nxt = WAIT_WRITE_ACC;
      WAIT_WRITE_ACC: begin
        if (!seq.done)     state_nxt = WAIT_WRITE;
        else if (wdog_last) begin wdog_hit = 1'b1; state_nxt = IDLE; end
      end
      WAIT_WRITE: begin
        if (seq.done)      begin wr_done = 1'b1; state_nxt = IDLE; end
        else if (wdog_last) begin wdog_hit = 1'b1; state_nxt = IDLE; end
      end
      default:     state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state         <= IDLE;
      wdog_cnt      <= '0;
      joint_angle   <= '0;
      angle_valid   <= 1'b0;
      frame_pending <= '0;
      error_count   <= '0;
      timeout_count <= '0;
      overrun_count <= '0;
      for (int b = 0; b < 4; b++) begin
        stage[b] <= '0;
        frame[b] <= '0;
      end
`ifdef ANGLE_FILTER_EN
      first_good    <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      if (state_nxt != state || !in_wait) wdog_cnt <= '0;
      else                                wdog_cnt <= wdog_cnt + 1'b1;

      angle_valid <= 1'b0;
      if (rd_done) begin
        if (seq.ack_error) begin
          error_count <= sat_inc(error_count);
        end else begin
`ifdef ANGLE_FILTER_EN
          joint_angle <= first_good ? filt_step(joint_angle, seq.angle) : seq.angle;
          first_good  <= 1'b1;
`else
          joint_angle <= seq.angle;
`endif
          angle_valid <= 1'b1;
        end
      end
      if (wr_done && seq.ack_error) error_count <= sat_inc(error_count);
      if (wdog_hit)                 timeout_count <= sat_inc(timeout_count);
      if (tick && state != IDLE)    overrun_count <= sat_inc(overrun_count);

      // Commit reads the pre-write stage; a same-cycle word-2 write re-sets pending below.
      if (state == ISSUE_WRITE) begin
        for (int b = 0; b < 4; b++)
          if (frame_pending[b]) frame[b] <= stage[b];
        frame_pending <= '0;
      end
      if (wr_en) begin
        case (wr_addr[1:0])
          2'd0: stage[wr_addr[3:2]][31:0]  <= wr_data;
          2'd1: stage[wr_addr[3:2]][63:32] <= wr_data;
          2'd2: begin
            stage[wr_addr[3:2]][87:64]   <= wr_data[23:0];
            frame_pending[wr_addr[3:2]]  <= 1'b1;
          end
          default: ;
        endcase
      end
    end
  end
endmodule

// File: tb/tb_arm_poll_scheduler.sv
// Directed bench for arm_poll_scheduler with a behavioural I2C sequencer model (TICK=16, WDOG=32).
module tb_arm_poll_scheduler;
  localparam int TICK = 16;
  localparam int WDOG = 32;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        wr_en = 1'b0;
  logic [3:0]  wr_addr = '0;
  logic [31:0] wr_data = '0;
  logic [11:0] joint_angle;
  logic        angle_valid;
  logic [3:0]  frame_pending;
  logic [7:0]  error_count, timeout_count, overrun_count;
  logic        busy;

  arm_poll_scheduler_if sq();

  arm_poll_scheduler #(.TICK_CYCLES(TICK), .WDOG_CYCLES(WDOG)) dut (
    .clock(clock), .reset(reset), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .seq(sq), .joint_angle(joint_angle), .angle_valid(angle_valid),
    .frame_pending(frame_pending), .error_count(error_count),
    .timeout_count(timeout_count), .overrun_count(overrun_count), .busy(busy)
  );

  always #5 clock = ~clock;

  int cyc = 0;
  int tests = 0, fails = 0;
  int rd_hi = 0, wr_hi = 0, av_hi = 0;
  int drop_dly = 2, low_len = 10;
  bit never_drop = 1'b0, ret_nak = 1'b0;
  logic [11:0] ret_angle = 12'h3A5;

  always @(posedge clock) cyc <= cyc + 1;

  always @(negedge clock) begin
    if (sq.elbow_read_joint_angle === 1'b1) rd_hi <= rd_hi + 1;
    if (sq.write_hand === 1'b1)             wr_hi <= wr_hi + 1;
    if (angle_valid === 1'b1)               av_hi <= av_hi + 1;
  end

  // Sequencer model: done idles high, drops drop_dly cycles after a trigger, rises low_len later.
  initial begin
    sq.done = 1'b1; sq.angle = '0; sq.ack_error = 1'b0;
    forever begin
      @(negedge clock);
      if ((sq.elbow_read_joint_angle === 1'b1 || sq.write_hand === 1'b1) && !never_drop) begin
        repeat (drop_dly) @(negedge clock);
        sq.done = 1'b0;
        repeat (low_len) @(negedge clock);
        sq.angle = ret_angle; sq.ack_error = ret_nak; sq.done = 1'b1;
      end
    end
  end

  task automatic check(input string tag, input logic [87:0] got, input logic [87:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic host_write(input logic [3:0] a, input logic [31:0] d);
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(negedge clock);
    wr_en = 1'b0;
  endtask

  task automatic wait_trig(input bit wr, input int bound, input string tag, output int at);
    at = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if ((wr ? sq.write_hand : sq.elbow_read_joint_angle) === 1'b1) begin
        at = cyc;
        break;
      end
    end
    check(tag, 88'(at >= 0), 88'(1));
  endtask

  task automatic check_all_clear(input string tag);
    check({tag, "_busy"},    88'(busy), 88'(0));
    check({tag, "_joint"},   88'(joint_angle), 88'(0));
    check({tag, "_av"},      88'(angle_valid), 88'(0));
    check({tag, "_pending"}, 88'(frame_pending), 88'(0));
    check({tag, "_errs"},    88'(error_count), 88'(0));
    check({tag, "_tmo"},     88'(timeout_count), 88'(0));
    check({tag, "_ovr"},     88'(overrun_count), 88'(0));
    check({tag, "_trig"},    88'({sq.elbow_read_joint_angle, sq.write_hand}), 88'(0));
    check({tag, "_f0"},      sq.arm_board_commandFrame_0, 88'(0));
    check({tag, "_f1"},      sq.arm_board_commandFrame_1, 88'(0));
    check({tag, "_f2"},      sq.arm_board_commandFrame_2, 88'(0));
    check({tag, "_f3"},      sq.arm_board_commandFrame_3, 88'(0));
  endtask

  initial begin
    int rel, t0, t1, w, w2, w3, td, t, t2, av0, wrs;
    repeat (3) @(negedge clock);
    check_all_clear("rst");
    reset = 1'b0;
    rel = cyc;

    // Periodic reads with a good angle, no staged frames.
    wait_trig(1'b0, 40, "rd0_seen", t0);
    check("rd0_latency", 88'(t0 - rel), 88'(16));
    wait_trig(1'b0, 40, "rd1_seen", t1);
    check("rd_period", 88'(t1 - t0), 88'(16));
    repeat (14) @(negedge clock);
    check("joint_good", 88'(joint_angle), 88'(12'h3A5));
    check("rd_pulse_cycles", 88'(rd_hi), 88'(2));
    check("av_pulse_cycles", 88'(av_hi), 88'(2));
    check("no_write_hand", 88'(wr_hi), 88'(0));

    // Stage board 2 and let the next poll commit it.
    low_len = 4;
    host_write(4'b1000, 32'h11223344);
    host_write(4'b1001, 32'h55667788);
    host_write(4'b1010, 32'h00AABBCC);
    check("pending_b2", 88'(frame_pending), 88'(4'b0100));
    check("f2_not_yet", sq.arm_board_commandFrame_2, 88'(0));
    wait_trig(1'b1, 40, "wr0_seen", w);
    repeat (10) @(negedge clock);
    check("f2_commit", sq.arm_board_commandFrame_2, 88'hAABBCC_55667788_11223344);
    check("pending_clr", 88'(frame_pending), 88'(0));
    check("wr_once", 88'(wr_hi), 88'(1));

    // Word-2 write during the commit cycle: old stage committed, pending stays set.
    host_write(4'b1000, 32'hDEADBEEF);
    host_write(4'b1001, 32'h01234567);
    host_write(4'b1010, 32'h00778899);
    wait_trig(1'b1, 40, "wr1_seen", w2);
    host_write(4'b1010, 32'hFF5A5A5A);
    check("f2_prewrite", sq.arm_board_commandFrame_2, 88'h778899_01234567_DEADBEEF);
    check("pending_wins", 88'(frame_pending), 88'(4'b0100));
    wait_trig(1'b1, 60, "wr2_seen", w3);
    repeat (2) @(negedge clock);
    check("f2_recommit", sq.arm_board_commandFrame_2, 88'h5A5A5A_01234567_DEADBEEF);
    check("pending_clr2", 88'(frame_pending), 88'(0));
    repeat (8) @(negedge clock);
    check("wr_count", 88'(wr_hi), 88'(3));
    check("f0_untouched", sq.arm_board_commandFrame_0, 88'(0));
    check("f1_untouched", sq.arm_board_commandFrame_1, 88'(0));
    check("f3_untouched", sq.arm_board_commandFrame_3, 88'(0));
    check("no_overrun", 88'(overrun_count), 88'(0));

    // NAK on a read: error counted, angle held, no valid pulse.
    wait_trig(1'b0, 40, "rd_nak_seen", td);
    ret_nak = 1'b1; ret_angle = 12'h0FF;
    av0 = av_hi;
    repeat (10) @(negedge clock);
    check("nak_errs", 88'(error_count), 88'(1));
    check("nak_joint_held", 88'(joint_angle), 88'(12'h3A5));
    check("nak_no_av", 88'(av_hi), 88'(av0));
    ret_nak = 1'b0;

    // Sequencer never drops done: watchdog abort, two ticks lost, polling resumes.
    never_drop = 1'b1;
    wait_trig(1'b0, 40, "rd_tmo_seen", t);
    repeat (40) @(negedge clock);
    check("tmo_count", 88'(timeout_count), 88'(1));
    check("tmo_idle", 88'(busy), 88'(0));
    check("ovr_count", 88'(overrun_count), 88'(2));
    check("tmo_joint_held", 88'(joint_angle), 88'(12'h3A5));
    never_drop = 1'b0; ret_angle = 12'h5C3;
    wait_trig(1'b0, 30, "rd_after_tmo", t2);
    check("resume_period", 88'(t2 - t), 88'(48));
    repeat (10) @(negedge clock);
    check("joint_new", 88'(joint_angle), 88'(12'h5C3));
    check("errs_stable", 88'(error_count), 88'(1));

    // Reset in the middle of a write transaction.
    host_write(4'b0100, 32'hCAFEF00D);
    host_write(4'b0110, 32'h00ABCDEF);
    wait_trig(1'b1, 40, "wr_rst_seen", w);
    repeat (4) @(negedge clock);
    check("pre_rst_busy", 88'(busy), 88'(1));
    check("pre_rst_f1", sq.arm_board_commandFrame_1, 88'hABCDEF_00000000_CAFEF00D);
    reset = 1'b1;
    @(negedge clock);
    check_all_clear("midrst");
    reset = 1'b0;
    rel = cyc;
    wrs = wr_hi;
    wait_trig(1'b0, 40, "rd_after_rst", t);
    check("rst_rd_latency", 88'(t - rel), 88'(16));
    check("rst_no_write", 88'(wr_hi), 88'(wrs));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got %0d cycles, expected completion", cyc);
    $fatal(1, "bench did not complete");
  end
endmodule

// File: doc/arm_poll_scheduler.md
Name: arm_poll_scheduler

Overview:
- Upstream driver for the arm I2C sequencer.
- Generates periodic elbow angle reads and hand-frame writes, and holds host command frames in staging registers.
- Presents stable 88-bit frames to the sequencer and commits them only between transactions.
- Latches the returned joint angle and tracks errors, timeouts and tick overruns for host readback.

Parameters:
TICK_CYCLES, 500000, poll period in clock cycles (100 Hz at 50 MHz); minimum 4
WDOG_CYCLES, 65535, max cycles to wait for sequencer done before abort

Ports:
clock  in  1  system clock
reset  in  1  synchronous, active-high reset
wr_en  in  1  host staging write strobe
wr_addr  in  4  {board[1:0], word[1:0]}
wr_data  in  32  host write data
done  in  1  sequencer idle/complete flag
angle  in  12  sequencer angle result
ack_error  in  1  sequencer I2C NAK flag
elbow_read_joint_angle  out  1  one-cycle read trigger
write_hand  out  1  one-cycle write trigger
arm_board_commandFrame_0..3  out  88 each  committed frames to sequencer
joint_angle  out  12  last good angle
angle_valid  out  1  one-cycle pulse on joint_angle update
frame_pending  out  4  staged-but-uncommitted flag per board
error_count  out  8  saturating NAK count
timeout_count  out  8  saturating watchdog abort count
overrun_count  out  8  saturating count of ticks lost while busy
busy  out  1  FSM not in IDLE

Behaviour:
- Reset: one clock, synchronous, active-high. All outputs, staging registers, committed frames, counters and FSM go to 0/IDLE. Reset mid-transaction abandons the transaction with no further triggers.
- Tick counter: counts 0..TICK_CYCLES-1 and wraps. tick=1 on the wrap cycle. Runs continuously, independent of the FSM.
- Staging writes (wr_en=1):
  - word 0 -> stage[b][31:0]
  - word 1 -> stage[b][63:32]
  - word 2 -> stage[b][87:64] from wr_data[23:0], and sets frame_pending[b]
  - word 3 ignored
- FSM states IDLE, ISSUE_READ, WAIT_READ_ACC, WAIT_READ, ISSUE_WRITE, WAIT_WRITE_ACC, WAIT_WRITE:
  - IDLE: on tick -> ISSUE_READ.
  - ISSUE_READ: elbow_read_joint_angle=1 for exactly this cycle -> WAIT_READ_ACC. Trigger appears 1 cycle after tick.
  - WAIT_READ_ACC: wait for done=0 -> WAIT_READ.
  - WAIT_READ: on done=1:
    - ack_error=0: joint_angle<=angle, angle_valid pulses the next cycle.
    - ack_error=1: error_count++ and joint_angle is held.
    - Then: if frame_pending!=0 -> ISSUE_WRITE, else -> IDLE.
  - ISSUE_WRITE: for every pending board b, commandFrame_b<=stage[b] and frame_pending[b] cleared, all in this same cycle. write_hand=1 this cycle -> WAIT_WRITE_ACC.
  - WAIT_WRITE_ACC and WAIT_WRITE: same handshake as the read path. A NAK on done increments error_count. -> IDLE.
- Watchdog: counts cycles spent in any WAIT_* state and clears on state change. On reaching WDOG_CYCLES: timeout_count++ -> IDLE; no angle update and no re-commit.
- Committed frames: change only in ISSUE_WRITE, so they are stable for the whole sequencer transaction.
- Overrun: tick while FSM≠IDLE -> overrun_count++ and the tick is dropped, not queued.
- All three counters saturate at 255.
- Simultaneous events:
  - Staging write and commit of the same board in the same cycle: the commit takes the pre-write stage value.
  - Word-2 write and pending clear in the same cycle: pending ends at 1 (write wins).
- done=1 already in a WAIT_*_ACC state is not treated as completion; only a 0 then 1 sequence completes.

Optional Feature:
- Macro: ANGLE_FILTER_EN.
- Defined: joint_angle <= joint_angle + ((angle - joint_angle) >>> 2).
  - Computed in 13-bit signed, result 12-bit.
  - The first good sample after reset loads directly.
  - angle_valid timing unchanged.
- Undefined: joint_angle loads the raw angle.

Test Plan:
- TICK_CYCLES=16, sequencer model drops done 2 cycles after trigger and raises it 10 cycles later with angle=12'h3A5 -> one read pulse per 16 cycles; joint_angle=12'h3A5; angle_valid high 1 cycle; write_hand never asserted.
- Write board2 words 0,1,2 = 32'h11223344, 32'h55667788, 32'h00AABBCC -> frame_pending=4'b0100. After the next read: commandFrame_2=88'hAABBCC_55667788_11223344; pending=0; write_hand pulsed once. Other frames remain 0.
- Sequencer model never drops done, WDOG_CYCLES=32 -> timeout_count=1; FSM returns to IDLE; next tick issues a new read.
- Model returns done with ack_error=1 and angle=12'h0FF -> error_count=1; joint_angle unchanged; no angle_valid.
- Hold done low for 40 cycles with TICK_CYCLES=16 -> overrun_count=2; each missed tick counted once; no extra trigger pulses.
- Assert reset during WAIT_WRITE -> next cycle all frames, counters and busy are 0; no triggers until the next tick.
